// File: rtl/scaler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scaler_pkg
// Description : Shared widths and read-sequence state encoding for the
//               scaler channel reader and its strobe timer.
// Revision    : 1.0 - initial release
// ============================================================================
package scaler_pkg;

   // One scaler word, and the combined {high,low} snapshot
   localparam int SCALER_W = 14;
   localparam int SNAP_W   = 2 * SCALER_W;

   // Read-sequence states; the reader keeps these as plain 3-bit codes
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD_HI  = 3'd1,
      RD_LO  = 3'd2,
      RD_HI2 = 3'd3,
      DONE   = 3'd4
   } state_e;

endpackage : scaler_pkg
`default_nettype wire

// File: rtl/scaler_channel_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : scaler_channel_reader_if
// Description : Request/snapshot handshake plus the scaler read bus
//               (active-low strobes and the two 14-bit words).
//               With SCALER_DELTA_EN defined a 28-bit delta output is added.
// Revision    : 1.0 - initial release
// ============================================================================
interface scaler_channel_reader_if;
   import scaler_pkg::*;

   logic                rd_req;
   logic                rd_busy;
   logic                RCHAT_;
   logic                RCHBT_;
   logic [SCALER_W-1:0] CHAT;
   logic [SCALER_W-1:0] CHBT;
   logic [SNAP_W-1:0]   snapshot;
   logic                snap_valid;
   logic                snap_err;
`ifdef SCALER_DELTA_EN
   logic [SNAP_W-1:0]   delta;
`endif

`ifdef SCALER_DELTA_EN
   // Reader side: drives strobes and results, samples request and words
   modport master (
      input  rd_req, CHAT, CHBT,
      output rd_busy, RCHAT_, RCHBT_, snapshot, snap_valid, snap_err, delta
   );
   // Environment side: scaler words and the requesting logic
   modport slave (
      output rd_req, CHAT, CHBT,
      input  rd_busy, RCHAT_, RCHBT_, snapshot, snap_valid, snap_err, delta
   );
`else
   // Reader side: drives strobes and results, samples request and words
   modport master (
      input  rd_req, CHAT, CHBT,
      output rd_busy, RCHAT_, RCHBT_, snapshot, snap_valid, snap_err
   );
   // Environment side: scaler words and the requesting logic
   modport slave (
      output rd_req, CHAT, CHBT,
      input  rd_busy, RCHAT_, RCHBT_, snapshot, snap_valid, snap_err
   );
`endif

endinterface : scaler_channel_reader_if
`default_nettype wire

// File: rtl/scaler_strobe_timer.sv
`default_nettype none
// ============================================================================
// Module      : scaler_strobe_timer
// Description : Settle counter for one read phase. While active_i is high a
//               phase lasts SETTLE_CYC+1 cycles: SETTLE_CYC cycles with the
//               strobe low (sample_o on the last of them) followed by one gap
//               cycle (gap_o) with both strobes released. The counter
//               restarts at 0 after the gap, so back-to-back phases chain.
// Revision    : 1.0 - initial release
// ============================================================================
module scaler_strobe_timer #(
   parameter int unsigned SETTLE_CYC = 2
) (
   input  logic SIM_CLK,
   input  logic SIM_RST,
   input  logic active_i,
   output logic sample_o,
   output logic gap_o
);

   // Counts 0..SETTLE_CYC, which fits in 4 bits for SETTLE_CYC up to 15
   localparam logic [3:0] LAST_LOW = 4'(SETTLE_CYC - 1);
   localparam logic [3:0] GAP_CNT  = 4'(SETTLE_CYC);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   // Next settle count: held at 0 outside a phase, restarts after the gap
   always_comb begin
      cnt_d = cnt_q;
      if (!active_i) begin
         cnt_d = 4'd0;
      end else if (cnt_q == GAP_CNT) begin
         cnt_d = 4'd0;
      end else begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   // Settle counter register
   always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
      if (SIM_RST) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign sample_o = active_i && (cnt_q == LAST_LOW);
   assign gap_o    = active_i && (cnt_q == GAP_CNT);

endmodule : scaler_strobe_timer
`default_nettype wire

// File: rtl/scaler_channel_reader.sv
`default_nettype none
// ============================================================================
// Module      : scaler_channel_reader
// Description : Reads the 14-bit high (CHBT) and low (CHAT) scaler words via
//               the active-low strobes RCHBT_/RCHAT_ and returns a coherent
//               28-bit {high,low} snapshot. The high word is read again after
//               the low word; if it moved, the low/high pair is re-read up to
//               MAX_RETRY times before the result is flagged with snap_err.
//               Optional feature macro: SCALER_DELTA_EN adds a delta output
//               (snapshot minus previous good snapshot, mod 2^28).
// Revision    : 1.0 - initial release
// ============================================================================
module scaler_channel_reader
   import scaler_pkg::*;
#(
   parameter int unsigned SETTLE_CYC = 2,
   parameter int unsigned MAX_RETRY  = 3
) (
   input  logic                    SIM_CLK,
   input  logic                    SIM_RST,
   scaler_channel_reader_if.master bus
);

   localparam logic [2:0] S_IDLE   = IDLE;
   localparam logic [2:0] S_RD_HI  = RD_HI;
   localparam logic [2:0] S_RD_LO  = RD_LO;
   localparam logic [2:0] S_RD_HI2 = RD_HI2;
   localparam logic [2:0] S_DONE   = DONE;

   localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

   logic [2:0]          state_q,      state_d;
   logic [2:0]          retry_q,      retry_d;
   logic [SCALER_W-1:0] hi0_q,        hi0_d;
   logic [SCALER_W-1:0] hi1_q,        hi1_d;
   logic [SCALER_W-1:0] lo_q,         lo_d;
   logic [SNAP_W-1:0]   snapshot_q,   snapshot_d;
   logic                snap_valid_q, snap_valid_d;
   logic                snap_err_q,   snap_err_d;

   logic w_phase_active;
   logic w_sample;
   logic w_gap;
   logic w_hi_phase;

   assign w_phase_active = (state_q == S_RD_HI) || (state_q == S_RD_LO) ||
                           (state_q == S_RD_HI2);
   assign w_hi_phase     = (state_q == S_RD_HI) || (state_q == S_RD_HI2);

   scaler_strobe_timer #(
      .SETTLE_CYC (SETTLE_CYC)
   ) u_timer (
      .SIM_CLK  (SIM_CLK),
      .SIM_RST  (SIM_RST),
      .active_i (w_phase_active),
      .sample_o (w_sample),
      .gap_o    (w_gap)
   );

   // Read sequencer: sample on the last settle cycle, advance after the gap
   always_comb begin
      state_d      = state_q;
      retry_d      = retry_q;
      hi0_d        = hi0_q;
      hi1_d        = hi1_q;
      lo_d         = lo_q;
      snapshot_d   = snapshot_q;
      snap_valid_d = 1'b0;
      snap_err_d   = snap_err_q;
      case (state_q)
         S_IDLE: begin
            if (bus.rd_req) begin
               state_d = S_RD_HI;
               retry_d = 3'd0;
            end
         end
         S_RD_HI: begin
            if (w_sample) hi0_d = bus.CHBT;
            if (w_gap)    state_d = S_RD_LO;
         end
         S_RD_LO: begin
            if (w_sample) lo_d = bus.CHAT;
            if (w_gap)    state_d = S_RD_HI2;
         end
         S_RD_HI2: begin
            if (w_sample) hi1_d = bus.CHBT;
            if (w_gap) begin
               if (hi1_q == hi0_q) begin
                  state_d      = S_DONE;
                  snapshot_d   = {hi1_q, lo_q};
                  snap_valid_d = 1'b1;
                  snap_err_d   = 1'b0;
               end else if (retry_q < RETRY_LIMIT) begin
                  // High word moved during the read: the latest high value
                  // becomes the new reference and the low word is re-read
                  retry_d = retry_q + 3'd1;
                  hi0_d   = hi1_q;
                  state_d = S_RD_LO;
               end else begin
                  state_d      = S_DONE;
                  snapshot_d   = {hi1_q, lo_q};
                  snap_valid_d = 1'b1;
                  snap_err_d   = 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Sequencer and result registers; reset aborts any read in progress
   always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
      if (SIM_RST) begin
         state_q      <= S_IDLE;
         retry_q      <= 3'd0;
         hi0_q        <= '0;
         hi1_q        <= '0;
         lo_q         <= '0;
         snapshot_q   <= '0;
         snap_valid_q <= 1'b0;
         snap_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         retry_q      <= retry_d;
         hi0_q        <= hi0_d;
         hi1_q        <= hi1_d;
         lo_q         <= lo_d;
         snapshot_q   <= snapshot_d;
         snap_valid_q <= snap_valid_d;
         snap_err_q   <= snap_err_d;
      end
   end

   // Strobes decode straight from state so reset releases them at once;
   // the states are exclusive, so both strobes can never be low together
   assign bus.RCHBT_     = ~(w_hi_phase && !w_gap);
   assign bus.RCHAT_     = ~((state_q == S_RD_LO) && !w_gap);
   // Busy covers the read phases and drops in the snap_valid cycle
   assign bus.rd_busy    = w_phase_active;
   assign bus.snapshot   = snapshot_q;
   assign bus.snap_valid = snap_valid_q;
   assign bus.snap_err   = snap_err_q;

`ifdef SCALER_DELTA_EN
   logic [SNAP_W-1:0] prev_q;
   logic [SNAP_W-1:0] delta_q;

   // Difference to the previous good snapshot; error reads leave it unchanged
   always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
      if (SIM_RST) begin
         prev_q  <= '0;
         delta_q <= '0;
      end else if (snap_valid_d) begin
         delta_q <= snapshot_d - prev_q;
         if (!snap_err_d) prev_q <= snapshot_d;
      end
   end

   assign bus.delta = delta_q;
`endif

endmodule : scaler_channel_reader
`default_nettype wire

// File: tb/tb_scaler_channel_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_scaler_channel_reader
// Description : Self-checking bench for scaler_channel_reader. Each segment
//               starts from reset with a precomputed stimulus table; a
//               transaction-level model derives the expected per-cycle
//               outputs, and one compare process checks them every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scaler_channel_reader;
   import scaler_pkg::*;

   localparam int S    = 2;
   localparam int MR   = 3;
   localparam int NMAX = 256;

   logic SIM_CLK = 1'b0;
   logic SIM_RST = 1'b1;

   scaler_channel_reader_if bus();

   scaler_channel_reader #(
      .SETTLE_CYC (S),
      .MAX_RETRY  (MR)
   ) dut (
      .SIM_CLK (SIM_CLK),
      .SIM_RST (SIM_RST),
      .bus     (bus)
   );

   always #5 SIM_CLK = ~SIM_CLK;

   int checks = 0;
   int errors = 0;

   // Stimulus table and model expectations, indexed by cycle within segment
   logic               st_req [NMAX];
   logic [13:0]        st_hi  [NMAX];
   logic [13:0]        st_lo  [NMAX];
   logic               ex_valid [NMAX];
   logic               ex_busy  [NMAX];
   logic               ex_a_n   [NMAX];
   logic               ex_b_n   [NMAX];
   logic               ex_err   [NMAX];
   logic [27:0]        ex_snap  [NMAX];
   logic [27:0]        ex_delta [NMAX];

   logic chk_en  = 1'b0;
   int   cur_cyc = 0;
   int   cc;
   int   obs_cnt;
   int   obs_cyc;
   logic [27:0] obs_snap;
   logic        obs_err;
   logic [27:0] obs_delta [3];

   function automatic void chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t actual=%b expected=%b", nm, $time, act, exp);
      end
   endfunction

   function automatic void chkw(input string nm, input logic [27:0] act, input logic [27:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t actual=%07h expected=%07h", nm, $time, act, exp);
      end
   endfunction

   function automatic void chki(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s t=%0t actual=%0d expected=%0d", nm, $time, act, exp);
      end
   endfunction

   // One strobe phase starting at cycle p: S low cycles plus one gap cycle
   function automatic void mark_phase(input int p, input bit high_word);
      for (int i = p; i < p + S; i++) begin
         if (high_word) ex_b_n[i] = 1'b0;
         else           ex_a_n[i] = 1'b0;
      end
      for (int i = p; i <= p + S; i++) ex_busy[i] = 1'b1;
   endfunction

   // Transaction-level model: walk the request table, for each accepted
   // request list the phase sequence HI, (LO, HI2)+ and read the words the
   // table presents on the last low cycle of each phase.
   function automatic void build_model(input int len);
      int t, p, retries;
      logic [13:0] h0, h1, l;
      logic [27:0] cur, prev;
      bit err;
      for (int c = 0; c < NMAX; c++) begin
         ex_valid[c] = 1'b0; ex_busy[c] = 1'b0; ex_a_n[c] = 1'b1;
         ex_b_n[c] = 1'b1;   ex_err[c]  = 1'b0; ex_snap[c] = '0; ex_delta[c] = '0;
      end
      prev = '0;
      t = 0;
      while (t < len) begin
         if (!st_req[t]) begin
            t++;
         end else begin
            p = t + 1;
            h0 = st_hi[p + S - 1]; mark_phase(p, 1'b1); p += S + 1;
            retries = 0;
            err = 1'b0;
            h1 = '0; l = '0;
            while (1) begin
               l  = st_lo[p + S - 1]; mark_phase(p, 1'b0); p += S + 1;
               h1 = st_hi[p + S - 1]; mark_phase(p, 1'b1); p += S + 1;
               if (h1 == h0) break;
               if (retries == MR) begin err = 1'b1; break; end
               retries++;
               h0 = h1;
            end
            ex_valid[p] = 1'b1;
            ex_err[p]   = err;
            ex_snap[p]  = {h1, l};
            ex_delta[p] = {h1, l} - prev;
            if (!err) prev = {h1, l};
            t = p + 1;
         end
      end
      // Snapshot holds between valid pulses and is zero after reset
      cur = '0;
      for (int c = 0; c < NMAX; c++) begin
         if (ex_valid[c]) cur = ex_snap[c];
         ex_snap[c] = cur;
      end
   endfunction

   // Per-cycle compare against the model
   always @(negedge SIM_CLK) begin
      if (chk_en) begin
         cc = cur_cyc;
         chk1("snap_valid", bus.snap_valid, ex_valid[cc]);
         chk1("rd_busy",    bus.rd_busy,    ex_busy[cc]);
         chk1("RCHAT_",     bus.RCHAT_,     ex_a_n[cc]);
         chk1("RCHBT_",     bus.RCHBT_,     ex_b_n[cc]);
         chkw("snapshot",   bus.snapshot,   ex_snap[cc]);
         chk1("strobes_not_both_low", bus.RCHAT_ | bus.RCHBT_, 1'b1);
         if (ex_valid[cc]) begin
            chk1("snap_err", bus.snap_err, ex_err[cc]);
`ifdef SCALER_DELTA_EN
            chkw("delta", bus.delta, ex_delta[cc]);
`endif
         end
         if (bus.snap_valid === 1'b1) begin
            if (obs_cnt < 3) begin
`ifdef SCALER_DELTA_EN
               obs_delta[obs_cnt] = bus.delta;
`else
               obs_delta[obs_cnt] = '0;
`endif
            end
            obs_cnt++;
            obs_cyc  = cc;
            obs_snap = bus.snapshot;
            obs_err  = bus.snap_err;
         end
      end
   end

   task automatic do_reset;
      chk_en = 1'b0;
      bus.rd_req = 1'b0;
      @(posedge SIM_CLK); #1;
      SIM_RST = 1'b1;
      @(posedge SIM_CLK); #1;
      SIM_RST = 1'b0;
   endtask

   task automatic clear_stim(input logic [13:0] hi, input logic [13:0] lo);
      for (int c = 0; c < NMAX; c++) begin
         st_req[c] = 1'b0; st_hi[c] = hi; st_lo[c] = lo;
      end
   endtask

   task automatic run_segment(input int len);
      build_model(len);
      obs_cnt = 0; obs_cyc = -1; obs_snap = '0; obs_err = 1'b0;
      for (int c = 0; c < len; c++) begin
         bus.rd_req = st_req[c];
         bus.CHBT   = st_hi[c];
         bus.CHAT   = st_lo[c];
         cur_cyc    = c;
         chk_en     = 1'b1;
         @(posedge SIM_CLK); #1;
      end
      chk_en = 1'b0;
      bus.rd_req = 1'b0;
   endtask

   task automatic gen_random(input int len, input int mode);
      logic [13:0] h, l;
      h = 14'($urandom);
      l = 14'($urandom);
      for (int c = 0; c < NMAX; c++) begin
         st_req[c] = (c < len - 40) && ($urandom_range(0, 5) == 0);
         case (mode)
            0: ;
            1: begin
               if ($urandom_range(0, 5) == 0) h = h + 14'd1;
               l = 14'($urandom);
            end
            2: begin
               h = h + 14'd1;
               l = 14'($urandom);
            end
            default: begin
               if ($urandom_range(0, 1) == 1) h = 14'($urandom);
               l = 14'($urandom);
            end
         endcase
         st_hi[c] = h;
         st_lo[c] = l;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit found;
      int nv;
      bus.rd_req = 1'b0;
      bus.CHAT   = '0;
      bus.CHBT   = '0;
      repeat (2) @(posedge SIM_CLK);
      #1 SIM_RST = 1'b0;

      // Reset state
      chk1("rst_RCHAT_",     bus.RCHAT_,     1'b1);
      chk1("rst_RCHBT_",     bus.RCHBT_,     1'b1);
      chk1("rst_rd_busy",    bus.rd_busy,    1'b0);
      chk1("rst_snap_valid", bus.snap_valid, 1'b0);
      chk1("rst_snap_err",   bus.snap_err,   1'b0);
      chkw("rst_snapshot",   bus.snapshot,   28'h0);

      // Static words: coherent read, valid 10 cycles after the request cycle
      do_reset;
      clear_stim(14'h0123, 14'h3FFF);
      st_req[0] = 1'b1;
      run_segment(40);
      chk1("t1_model_valid_cyc", ex_valid[10], 1'b1);
      chki("t1_valid_count", obs_cnt, 1);
      chki("t1_valid_cyc",   obs_cyc, 10);
      chkw("t1_snapshot",    obs_snap, 28'h048FFFF);
      chk1("t1_snap_err",    obs_err, 1'b0);

      // High word moves 5->6 during the first low-word phase: one retry
      do_reset;
      clear_stim(14'd5, 14'h0AA);
      for (int c = 4; c < NMAX; c++) st_hi[c] = 14'd6;
      st_req[0] = 1'b1;
      run_segment(40);
      chk1("t2_model_valid_cyc", ex_valid[16], 1'b1);
      chki("t2_valid_cyc", obs_cyc, 16);
      chkw("t2_snapshot",  obs_snap, 28'h00180AA);
      chk1("t2_snap_err",  obs_err, 1'b0);

      // High word changes every cycle: retries exhausted, error flagged
      do_reset;
      clear_stim(14'h0, 14'h0);
      for (int c = 0; c < NMAX; c++) begin
         st_hi[c] = 14'(c);
         st_lo[c] = 14'(c + 16'h100);
      end
      st_req[0] = 1'b1;
      run_segment(40);
      chki("t3_valid_count", obs_cnt, 1);
      chki("t3_valid_cyc",   obs_cyc, 28);
      chk1("t3_snap_err",    obs_err, 1'b1);
      chkw("t3_snapshot",    obs_snap, 28'h0068117);

      // Reset mid-read while the low strobe is active
      do_reset;
      bus.CHBT = 14'h0123; bus.CHAT = 14'h3FFF; bus.rd_req = 1'b1;
      @(posedge SIM_CLK); #1;
      bus.rd_req = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (bus.RCHAT_ === 1'b0) found = 1'b1;
         else begin @(posedge SIM_CLK); #1; end
      end
      chk1("t4_rchat_went_low", found, 1'b1);
      #2 SIM_RST = 1'b1;
      #1;
      chk1("t4_async_RCHAT_",  bus.RCHAT_,  1'b1);
      chk1("t4_async_RCHBT_",  bus.RCHBT_,  1'b1);
      chk1("t4_async_rd_busy", bus.rd_busy, 1'b0);
      nv = 0;
      repeat (3) begin @(negedge SIM_CLK); if (bus.snap_valid === 1'b1) nv++; end
      @(posedge SIM_CLK); #1 SIM_RST = 1'b0;
      repeat (20) begin @(negedge SIM_CLK); if (bus.snap_valid === 1'b1) nv++; end
      chki("t4_no_valid_after_abort", nv, 0);
      do_reset;
      clear_stim(14'h0123, 14'h3FFF);
      st_req[0] = 1'b1;
      run_segment(40);
      chkw("t4_next_read_snapshot", obs_snap, 28'h048FFFF);

      // Requests during busy and in the snap_valid cycle are dropped
      do_reset;
      clear_stim(14'h2AAA, 14'h1555);
      st_req[0] = 1'b1; st_req[3] = 1'b1; st_req[7] = 1'b1; st_req[10] = 1'b1;
      run_segment(40);
      chki("t5_valid_count", obs_cnt, 1);
      chki("t5_valid_cyc",   obs_cyc, 10);

`ifdef SCALER_DELTA_EN
      // Delta across three reads, including the mod-2^28 wrap
      do_reset;
      clear_stim(14'h0, 14'h100);
      for (int c = 30; c < 60; c++) begin st_hi[c] = 14'h3FFF; st_lo[c] = 14'h3FF0; end
      for (int c = 60; c < NMAX; c++) begin st_hi[c] = 14'h0; st_lo[c] = 14'h10; end
      st_req[0] = 1'b1; st_req[30] = 1'b1; st_req[60] = 1'b1;
      run_segment(100);
      chki("t6_valid_count", obs_cnt, 3);
      chkw("t6_delta0", obs_delta[0], 28'h0000100);
      chkw("t6_delta1", obs_delta[1], 28'hFFFFEF0);
      chkw("t6_delta2", obs_delta[2], 28'h0000020);
`endif

      // Randomized segments over all stimulus styles
      for (int seg = 0; seg < 32; seg++) begin
         do_reset;
         gen_random(200, seg % 4);
         run_segment(200);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_scaler_channel_reader
`default_nettype wire
